// File: rtl/axi_modport_slave.sv
// AXI3-style memory-mapped slave with a word-addressed internal RAM.
// Independent write (AW/W/B) and read (AR/R) paths, one burst outstanding each.
// Optional feature macro: AXI_SLV_ERR_RESP_EN enables SLVERR responses for
// unsupported burst configurations, WID/WLAST mismatches and out-of-range
// accesses; without it responses are always OKAY and the word index wraps.
module axi_modport_slave #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LB     = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

`ifdef AXI_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic [2:0] clip_size(input logic [2:0] s);
    return (s > 3'(LB)) ? 3'(LB) : s;
  endfunction

  function automatic logic [1:0] eff_burst(input logic [1:0] b);
    return (b == 2'd3) ? 2'd1 : b;
  endfunction

  function automatic logic cfg_bad(input logic [2:0] s, input logic [1:0] b,
                                   input logic [LEN_W-1:0] len);
    logic wrap_ok;
    wrap_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
              (len == LEN_W'(7)) || (len == LEN_W'(15));
    return (s > 3'(LB)) || (b == 2'd3) || ((b == 2'd2) && !wrap_ok);
  endfunction

  // WRAP keeps the bits above the burst footprint and lets the low bits roll over
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
      input logic [LEN_W-1:0] len, input logic [2:0] s, input logic [1:0] b);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc  = ADDR_W'(1) << s;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << s) - ADDR_W'(1);
    case (b)
      2'd0:    return a;
      2'd2:    return (a & ~mask) | ((a + inc) & mask);
      default: return a + inc;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> LB);
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> LB) >= ADDR_W'(MEM_DEPTH);
  endfunction

  // ---------------- write path ----------------
  wstate_t           w_state, w_next;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] waddr;
  logic [LEN_W-1:0]  wlen, wcount;
  logic [2:0]        wsize;
  logic [1:0]        wburst;
  logic              werr;
  logic              aw_hs, w_hs, b_hs, w_drop, w_beat_err;

  assign aw_hs      = AWVALID & AWREADY;
  assign w_hs       = WVALID & WREADY;
  assign b_hs       = BVALID & BREADY;
  assign w_drop     = ERR_EN && out_of_range(waddr);
  assign w_beat_err = ERR_EN && (out_of_range(waddr) || (WID != aw_id) ||
                                 (WLAST != (wcount == wlen)));

  // Write FSM next-state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && WLAST) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, burst context and registered AW/W/B outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      aw_id   <= '0;
      waddr   <= '0;
      wlen    <= '0;
      wsize   <= '0;
      wburst  <= '0;
      wcount  <= '0;
      werr    <= 1'b0;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        aw_id  <= AWID;
        waddr  <= AWADDR;
        wlen   <= AWLEN;
        wsize  <= clip_size(AWSIZE);
        wburst <= eff_burst(AWBURST);
        wcount <= '0;
        werr   <= ERR_EN && cfg_bad(AWSIZE, AWBURST, AWLEN);
      end
      if (w_hs) begin
        waddr  <= next_addr(waddr, wlen, wsize, wburst);
        wcount <= wcount + LEN_W'(1);
        werr   <= werr | w_beat_err;
        if (WLAST) begin
          BID   <= aw_id;
          BRESP <= (werr | w_beat_err) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs && !w_drop) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[word_idx(waddr)][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t           r_state, r_next;
  logic [ADDR_W-1:0] raddr, r_nxt, r_sel;
  logic [LEN_W-1:0]  rlen, rcount;
  logic [2:0]        rsize;
  logic [1:0]        rburst;
  logic              rcfg_err, ar_hs, r_hs, r_oor, r_err;
  logic [DATA_W-1:0] r_word;

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Read FSM next-state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Address and data of the beat to present next (beat 0 on AR, else successor)
  always_comb begin
    r_nxt  = next_addr(raddr, rlen, rsize, rburst);
    r_sel  = ar_hs ? ARADDR : r_nxt;
    r_oor  = ERR_EN && out_of_range(r_sel);
    r_err  = r_oor || (ERR_EN && (ar_hs ? cfg_bad(ARSIZE, ARBURST, ARLEN) : rcfg_err));
    r_word = r_oor ? '0 : mem[word_idx(r_sel)];
  end

  // Read state, burst context and registered AR/R outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RID      <= '0;
      RDATA    <= '0;
      RRESP    <= '0;
      RLAST    <= 1'b0;
      raddr    <= '0;
      rlen     <= '0;
      rsize    <= '0;
      rburst   <= '0;
      rcount   <= '0;
      rcfg_err <= 1'b0;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        RID      <= ARID;
        raddr    <= ARADDR;
        rlen     <= ARLEN;
        rsize    <= clip_size(ARSIZE);
        rburst   <= eff_burst(ARBURST);
        rcount   <= '0;
        rcfg_err <= ERR_EN && cfg_bad(ARSIZE, ARBURST, ARLEN);
        RDATA    <= r_word;
        RRESP    <= r_err ? 2'b10 : 2'b00;
        RLAST    <= (ARLEN == '0);
      end else if (r_hs && !RLAST) begin
        raddr  <= r_nxt;
        rcount <= rcount + LEN_W'(1);
        RDATA  <= r_word;
        RRESP  <= r_err ? 2'b10 : 2'b00;
        RLAST  <= ((rcount + LEN_W'(1)) == rlen);
      end
    end
  end

endmodule

// File: tb/tb_axi_modport_slave.sv
// Self-checking bench for axi_modport_slave: directed cases plus randomized
// bursts compared against a word-array reference model.
// Honours AXI_SLV_ERR_RESP_EN to select the expected error behaviour.
module tb_axi_modport_slave;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, MEM_DEPTH = 256;
`ifdef AXI_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int TMO = 64;

  logic clk = 1'b0, rst = 1'b0;
  logic [ID_W-1:0] AWID = '0, WID = '0, BID, ARID = '0, RID;
  logic [ADDR_W-1:0] AWADDR = '0, ARADDR = '0;
  logic [LEN_W-1:0] AWLEN = '0, ARLEN = '0;
  logic [2:0] AWSIZE = '0, ARSIZE = '0;
  logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
  logic [DATA_W-1:0] WDATA = '0, RDATA;
  logic [DATA_W/8-1:0] WSTRB = '0;

  axi_modport_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .LEN_W(LEN_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  logic [31:0] mem_m [MEM_DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, computed from the burst definition
  function automatic int unsigned beat_addr(input int unsigned start, len, size, burst, i);
    int unsigned bytes, total, bnd;
    bytes = 1 << size;
    total = (len + 1) * bytes;
    case (burst)
      0: return start;
      2: begin
        bnd = (start / total) * total;
        return bnd + ((start - bnd) + i * bytes) % total;
      end
      default: return start + i * bytes;
    endcase
  endfunction

  function automatic bit beyond(input int unsigned a);
    return ERR_EN && ((a / 4) >= MEM_DEPTH);
  endfunction

  task automatic do_write(input logic [3:0] id, input int unsigned addr, len, size, burst,
                          nbeats, bstall);
    int n;
    int unsigned a;
    bit err;
    err = ERR_EN && (nbeats != len + 1);
    AWID = id; AWADDR = addr; AWLEN = LEN_W'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < TMO) begin @(posedge clk); #1; n++; end
    check("awready", AWREADY, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < int'(nbeats); i++) begin
      WID = id; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == int'(nbeats) - 1); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < TMO) begin @(posedge clk); #1; n++; end
      check("wready", WREADY, 1);
      @(posedge clk); #1;
      a = beat_addr(addr, len, size, burst, i);
      if (beyond(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (ws[i][b]) mem_m[(a / 4) % MEM_DEPTH][b*8 +: 8] = wd[i][b*8 +: 8];
      WVALID = 1'b0; WLAST = 1'b0;
      if (i != int'(nbeats) - 1 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    n = 0;
    while (!BVALID && n < TMO) begin @(posedge clk); #1; n++; end
    check("bvalid", BVALID, 1);
    for (int k = 0; k < int'(bstall); k++) begin
      @(posedge clk); #1;
      check("bvalid_hold", BVALID, 1);
    end
    check("bid", BID, id);
    check("bresp", BRESP, err ? 2 : 0);
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    check("bvalid_clr", BVALID, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input int unsigned addr, len, size, burst,
                         input bit stall);
    int n;
    int unsigned a;
    logic [31:0] expd;
    ARID = id; ARADDR = addr; ARLEN = LEN_W'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(posedge clk); #1; n++; end
    check("arready", ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < TMO) begin @(posedge clk); #1; n++; end
      check("rvalid", RVALID, 1);
      a = beat_addr(addr, len, size, burst, i);
      expd = beyond(a) ? 32'h0 : mem_m[(a / 4) % MEM_DEPTH];
      check("rdata", RDATA, expd);
      check("rresp", RRESP, beyond(a) ? 2 : 0);
      check("rlast", RLAST, i == int'(len));
      check("rid", RID, id);
      if (stall && $urandom_range(0, 1) == 1) begin
        RREADY = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        check("rvalid_stall", RVALID, 1);
        check("rdata_stall", RDATA, expd);
        check("rlast_stall", RLAST, i == int'(len));
      end
      RREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b0;
      if (i < int'(len)) check("rvalid_b2b", RVALID, 1);
    end
    check("rvalid_clr", RVALID, 0);
  endtask

  initial begin
    int unsigned len, size, burst, bytes, addr;
    logic [31:0] oldv, newv;
    int n;

    // Reset held while inputs toggle
    repeat (4) begin
      @(posedge clk); #1;
      AWVALID = 1'($urandom); WVALID = 1'($urandom); ARVALID = 1'($urandom);
      BREADY = 1'($urandom); RREADY = 1'($urandom); WLAST = 1'($urandom);
      AWADDR = $urandom; ARADDR = $urandom; WDATA = $urandom;
    end
    check("rst_ctl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 0);
    check("rst_ids", {BID, BRESP, RID, RRESP}, 0);
    check("rst_rdata", RDATA, 0);
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0; WLAST = 0;
    rst = 1'b1;
    #1 check("rdy_pre_edge", {AWREADY, ARREADY}, 0);
    @(posedge clk); #1;
    check("rdy_post_rel", {AWREADY, ARREADY}, 2'b11);

    // Fill the whole RAM with known data
    for (int blk = 0; blk < MEM_DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'(blk), blk * 64, 15, 2, 1, 16, 0);
    end

    // INCR write/read
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    do_write(3, 'h10, 3, 2, 1, 4, 0);
    do_read(3, 'h10, 3, 2, 1, 0);

    // Strobes, B backpressure, R backpressure
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(1, 'h40, 0, 2, 1, 1, 2);
    wd[0] = 32'h1234_5678; ws[0] = 4'h3;
    do_write(1, 'h40, 0, 2, 1, 1, 3);
    do_read(1, 'h40, 0, 2, 1, 1);
    check("strobe_word", RDATA, 32'hFFFF_5678);

    // WRAP read over 0x30..0x3C starting at 0x38
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + i; ws[i] = 4'hF; end
    do_write(2, 'h30, 3, 2, 1, 4, 0);
    do_read(2, 'h38, 3, 2, 2, 1);

    // Out-of-range read and early WLAST
    do_read(4, 'h400, 0, 2, 1, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(5, 'h80, 3, 2, 1, 3, 0);

    // Same-edge write and read of word 0x20: read sees old value
    oldv = mem_m['h20];
    newv = ~oldv;
    AWID = 6; AWADDR = 'h80; AWLEN = 0; AWSIZE = 2; AWBURST = 1; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < TMO) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WID = 6; WDATA = newv; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARID = 6; ARADDR = 'h80; ARLEN = 0; ARSIZE = 2; ARBURST = 1; ARVALID = 1'b1;
    check("conc_ready", {WREADY, ARREADY}, 2'b11);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    check("conc_rvalid", RVALID, 1);
    check("conc_old", RDATA, oldv);
    mem_m['h20] = newv;
    RREADY = 1'b1; BREADY = 1'b1;
    @(posedge clk); #1;
    RREADY = 1'b0; BREADY = 1'b0;
    check("conc_done", {BVALID, RVALID}, 0);
    do_read(6, 'h80, 0, 2, 1, 0);

    // Reset during a write burst
    AWID = 7; AWADDR = 'h100; AWLEN = 3; AWSIZE = 2; AWBURST = 1; AWVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WID = 7; WDATA = 32'h5A5A_0001; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    @(posedge clk); #1;
    mem_m['h40] = 32'h5A5A_0001;
    check("mid_wready", WREADY, 1);
    rst = 1'b0;
    #1;
    check("mid_rst", {WREADY, BVALID, AWREADY}, 0);
    WVALID = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_post", {AWREADY, WREADY, BVALID}, 3'b100);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_nob", BVALID, 0);
    do_read(8, 'h100, 3, 2, 1, 0);

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      burst = $urandom_range(0, 2);
      len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      size  = $urandom_range(0, 2);
      bytes = 1 << size;
      addr  = $urandom_range(0, 'h400 - (len + 1) * bytes) & ~(bytes - 1);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(4'($urandom), addr, len, size, burst, len + 1, $urandom_range(0, 2));
      burst = $urandom_range(0, 2);
      len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      size  = $urandom_range(0, 2);
      bytes = 1 << size;
      addr  = $urandom_range(0, 'h400 - (len + 1) * bytes) & ~(bytes - 1);
      do_read(4'($urandom), addr, len, size, burst, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
